// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel path: timing, modes and bar colours.
package vga_pkg;

    // Display timing (640x400 inside an 800x449 raster)
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 400;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 449;

    // Framebuffer geometry: 320x200, pixel-doubled on both axes
    localparam int unsigned FB_W   = H_ACTIVE / 2;
    localparam int unsigned ADDR_W = 16;

    // Field widths
    localparam int unsigned PIX_W   = 10;
    localparam int unsigned LINE_W  = 9;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned FRAME_W = 8;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned PAL_DEPTH = 16;

    // Colour bars: 8 bars across the active line
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    // Sync idle levels (hsync active low, vsync active high)
    localparam logic HS_IDLE = 1'b1;
    localparam logic VS_IDLE = 1'b0;

    typedef enum logic [MODE_W-1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRID  = 2'd3
    } mode_e;

    localparam logic [RGB_W-1:0] C_WHITE   = 12'hFFF;
    localparam logic [RGB_W-1:0] C_YELLOW  = 12'hFF0;
    localparam logic [RGB_W-1:0] C_CYAN    = 12'h0FF;
    localparam logic [RGB_W-1:0] C_GREEN   = 12'h0F0;
    localparam logic [RGB_W-1:0] C_MAGENTA = 12'hF0F;
    localparam logic [RGB_W-1:0] C_RED     = 12'hF00;
    localparam logic [RGB_W-1:0] C_BLUE    = 12'h00F;
    localparam logic [RGB_W-1:0] C_BLACK   = 12'h000;

    // Colour of bar n, left to right
    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            3'd0:    c = C_WHITE;
            3'd1:    c = C_YELLOW;
            3'd2:    c = C_CYAN;
            3'd3:    c = C_GREEN;
            3'd4:    c = C_MAGENTA;
            3'd5:    c = C_RED;
            3'd6:    c = C_BLUE;
            default: c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_palette_ram.sv
// 16x12 palette register file: one write port, one registered read port.
// The read register doubles as the final colour register: when rd_en is low
// it loads alt_data instead, so pattern colours and blanking share it.
module vga_palette_ram
    import vga_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [RGB_W-1:0] wdata,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] raddr,
    input  logic [RGB_W-1:0] alt_data,
    output logic [RGB_W-1:0] rdata
);

    logic [RGB_W-1:0] mem [PAL_DEPTH];

    // Write port; reset loads a grey ramp {i,i,i}
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PAL_DEPTH); i++) begin
                mem[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: a same-edge write is not visible, so the old entry is returned
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= alt_data;
        end
    end

endmodule

// File: rtl/vga_pixel_stage.sv
// VGA pixel stage: framebuffer fetch, palette lookup, test patterns and
// sync re-alignment. Fixed 3-cycle latency from counters to pins.
module vga_pixel_stage
    import vga_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [PIX_W-1:0]    pixel_cnt,
    input  logic [LINE_W-1:0]   line_cnt,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                blank_in,
    input  logic [MODE_W-1:0]   mode_req,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic                fb_re,
    input  logic [IDX_W-1:0]    fb_data,
    input  logic                pal_we,
    input  logic [IDX_W-1:0]    pal_addr,
    input  logic [RGB_W-1:0]    pal_wdata,
    output logic [RGB_W-1:0]    rgb,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic [FRAME_W-1:0]  frame_cnt,
    output logic [MODE_W-1:0]   mode_cur
);

    // Input-side decode
    logic                boundary_c;
    logic                in_active_c;
    logic [MODE_W-1:0]   mode_eff_c;
    logic                fetch_c;
    logic [ADDR_W-1:0]   addr_c;

    // S1 registers
    logic [PIX_W-1:0]    pixel_s1;
    logic [LINE_W-1:0]   line_s1;
    logic                blank_s1;
    logic [MODE_W-1:0]   mode_s1;

    // S1 pattern decode
    logic [2:0]          bar_idx_c;
    logic                checker_c;
    logic                grid_c;
    logic [RGB_W-1:0]    pat_c;

    // S2 registers
    logic [RGB_W-1:0]    pat_s2;
    logic                fetch_s2;

    // Sync delay lines, newest sample in bit 0
    logic [2:0]          hs_d;
    logic [2:0]          vs_d;

    // Frame boundary detection and the mode that applies to the incoming pixel
    always_comb begin
        boundary_c  = (pixel_cnt == '0) && (line_cnt == '0);
        in_active_c = (pixel_cnt < PIX_W'(H_ACTIVE)) && (line_cnt < LINE_W'(V_ACTIVE));
        mode_eff_c  = boundary_c ? mode_req : mode_cur;
        fetch_c     = !blank_in && in_active_c && (mode_eff_c == MODE_FB);
    end

    // Framebuffer address: (line/2)*320 + pixel/2 as (y<<8) + (y<<6) + x
    always_comb begin
        addr_c = (ADDR_W'(line_cnt[LINE_W-1:1]) << 8)
               + (ADDR_W'(line_cnt[LINE_W-1:1]) << 6)
               + ADDR_W'(pixel_cnt[PIX_W-1:1]);
    end

    // Mode latch and frame counter, updated only at the frame boundary
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_cur  <= MODE_FB;
            frame_cnt <= '0;
        end else if (boundary_c) begin
            mode_cur  <= mode_req;
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    // S1: register counters and issue the framebuffer read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_s1 <= '0;
            line_s1  <= '0;
            blank_s1 <= 1'b1;
            mode_s1  <= MODE_FB;
            fb_re    <= 1'b0;
            fb_addr  <= '0;
        end else begin
            pixel_s1 <= pixel_cnt;
            line_s1  <= line_cnt;
            blank_s1 <= blank_in;
            mode_s1  <= mode_eff_c;
            fb_re    <= fetch_c;
            if (fetch_c) begin
                fb_addr <= addr_c;
            end
        end
    end

    // Bar index from a descending compare chain; smallest matching bound wins
    always_comb begin
        bar_idx_c = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (pixel_s1 < PIX_W'((i + 1) * int'(BAR_W))) begin
                bar_idx_c = 3'(i);
            end
        end
    end

    // Checkerboard (phase flips every 32 frames) and grid decode
    always_comb begin
        checker_c = pixel_s1[4] ^ line_s1[4] ^ frame_cnt[5];
        grid_c    = (pixel_s1[5:0] == 6'd0)
                 || (line_s1[5:0] == 6'd0)
                 || (pixel_s1 == PIX_W'(H_ACTIVE - 1))
                 || (line_s1 == LINE_W'(V_ACTIVE - 1));
    end

    // Pattern colour for the S1 pixel; framebuffer mode contributes nothing here
    always_comb begin
        pat_c = C_BLACK;
        case (mode_s1)
            MODE_BARS:  pat_c = bar_colour(bar_idx_c);
            MODE_CHECK: pat_c = checker_c ? C_WHITE : C_BLACK;
            MODE_GRID:  pat_c = grid_c ? C_WHITE : C_BLACK;
            default:    pat_c = C_BLACK;
        endcase
    end

    // S2: hold the pattern colour (forced black in blanking) while fb_data arrives
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_s2   <= '0;
            fetch_s2 <= 1'b0;
        end else begin
            pat_s2   <= blank_s1 ? C_BLACK : pat_c;
            fetch_s2 <= fb_re;
        end
    end

    // S3: palette lookup for fetched pixels, otherwise the S2 colour
    vga_palette_ram u_palette (
        .clock    (clock),
        .reset    (reset),
        .we       (pal_we),
        .waddr    (pal_addr),
        .wdata    (pal_wdata),
        .rd_en    (fetch_s2),
        .raddr    (fb_data),
        .alt_data (pat_s2),
        .rdata    (rgb)
    );

    // Sync delay lines matching the 3-stage colour path
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_d <= {3{HS_IDLE}};
            vs_d <= {3{VS_IDLE}};
        end else begin
            hs_d <= {hs_d[1:0], hsync_in};
            vs_d <= {vs_d[1:0], vsync_in};
        end
    end

    assign hsync_out = hs_d[2];
    assign vsync_out = vs_d[2];

endmodule

// File: tb/tb_vga_pixel_stage.sv
// Bench for vga_pixel_stage: a timing-generator driver pushes expectations into
// queues, and a monitor pops them when the corresponding output is due.
module tb_vga_pixel_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  pixel_cnt = 10'd799;
    logic [8:0]  line_cnt = 9'd448;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b0;
    logic        blank_in = 1'b1;
    logic [1:0]  mode_req = 2'd0;
    logic [15:0] fb_addr;
    logic        fb_re;
    logic [3:0]  fb_data = 4'd0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = 4'd0;
    logic [11:0] pal_wdata = 12'd0;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic [7:0]  frame_cnt;
    logic [1:0]  mode_cur;

    vga_pixel_stage dut (
        .clock     (clock),
        .reset     (reset),
        .pixel_cnt (pixel_cnt),
        .line_cnt  (line_cnt),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .blank_in  (blank_in),
        .mode_req  (mode_req),
        .fb_addr   (fb_addr),
        .fb_re     (fb_re),
        .fb_data   (fb_data),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_wdata (pal_wdata),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .frame_cnt (frame_cnt),
        .mode_cur  (mode_cur)
    );

    always #5 clock = ~clock;

    // Framebuffer model: synchronous read, data = low nibble of the address
    always @(posedge clock) begin
        if (fb_re) fb_data <= fb_addr[3:0];
    end

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        int          px;
        int          ln;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } pix_exp_t;

    typedef struct {
        int unsigned due;
        int          px;
        int          ln;
        logic        re;
        logic [15:0] addr;
        logic [7:0]  frame;
        logic [1:0]  mode;
    } s1_exp_t;

    typedef struct {
        int          mode;
        int          px;
        int          ln;
        logic [11:0] rgb;
        int          addr;
    } dvec_t;

    pix_exp_t pq[$];
    s1_exp_t  s1q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-computed vectors that replace the model's answer at these points
    dvec_t dv [12] = '{
        '{1,   0,   0, 12'hFFF,    -1},
        '{1,  79,   0, 12'hFFF,    -1},
        '{1,  80,   0, 12'hFF0,    -1},
        '{1, 400,   0, 12'hF00,    -1},
        '{1, 560,   0, 12'h000,    -1},
        '{1, 639,   1, 12'h000,    -1},
        '{1, 700,   0, 12'h000,    -1},
        '{0,  10,   0, 12'h555,     5},
        '{0,  11,   0, 12'hA5C,     5},
        '{0,  42,   0, 12'hA5C,    21},
        '{0,   6,   2, 12'h333,   323},
        '{0, 639, 399, 12'hFFF, 63999}
    };

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // Reference state
    logic [11:0] pal_mdl [16];
    int          m_mode  = 0;
    int          m_frame = 0;
    logic        pw_sched = 1'b0;
    logic        pw_now   = 1'b0;
    logic [3:0]  pw_addr  = 4'd0;
    logic [11:0] pw_data  = 12'd0;

    task automatic chk(input string name, input int px, input int ln,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s px=%0d ln=%0d got=%0h exp=%0h", name, px, ln, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) pal_mdl[i] = {4'(i), 4'(i), 4'(i)};
        m_mode  = 0;
        m_frame = 0;
        pw_sched = 1'b0;
        pw_now   = 1'b0;
    endtask

    // One generator cycle at (px, ln) plus the expectations it implies
    task automatic drive(input int px, input int ln);
        pix_exp_t pe;
        s1_exp_t  se;
        logic     bl;
        logic     hs;
        logic     vs;
        int       addr;
        logic [11:0] c;
        @(posedge clock);
        #1;
        bl = (px >= 640) || (ln >= 400);
        hs = !((px >= 656) && (px < 752));
        vs = (ln >= 412) && (ln < 414);
        pixel_cnt = 10'(px);
        line_cnt  = 9'(ln);
        hsync_in  = hs;
        vsync_in  = vs;
        blank_in  = bl;
        pal_we    = pw_now;
        pal_addr  = pw_addr;
        pal_wdata = pw_data;
        pw_now    = 1'b0;
        // A write issued next cycle already lands before this pixel's lookup
        if (pw_sched) begin
            pal_mdl[pw_addr] = pw_data;
            pw_now   = 1'b1;
            pw_sched = 1'b0;
        end
        if (px == 0 && ln == 0) begin
            m_mode  = int'(mode_req);
            m_frame = (m_frame + 1) % 256;
        end
        addr = (ln / 2) * 320 + (px / 2);
        if (bl) c = 12'h000;
        else begin
            case (m_mode)
                0: c = pal_mdl[addr % 16];
                1: c = bars[px / 80];
                2: c = ((((px / 16) + (ln / 16)) % 2) != ((m_frame / 32) % 2)) ? 12'hFFF : 12'h000;
                default: c = ((px % 64 == 0) || (ln % 64 == 0) || (px == 639) || (ln == 399))
                             ? 12'hFFF : 12'h000;
            endcase
        end
        foreach (dv[i]) begin
            if (dv[i].mode == m_mode && dv[i].px == px && dv[i].ln == ln) begin
                c = dv[i].rgb;
                if (dv[i].addr >= 0) addr = dv[i].addr;
            end
        end
        pe.due = cyc + 3; pe.px = px; pe.ln = ln; pe.rgb = c; pe.hs = hs; pe.vs = vs;
        se.due = cyc + 1; se.px = px; se.ln = ln;
        se.re = !bl && (m_mode == 0);
        se.addr = 16'(addr);
        se.frame = 8'(m_frame);
        se.mode = 2'(m_mode);
        pq.push_back(pe);
        s1q.push_back(se);
    endtask

    task automatic drive_span(input int ln, input int p0, input int p1);
        for (int p = p0; p <= p1; p++) drive(p, ln);
    endtask

    // Monitor: compare each output when its expectation falls due
    always @(negedge clock) begin
        if (!reset) begin
            if (pq.size() > 0 && pq[0].due <= cyc) begin
                pix_exp_t e;
                e = pq.pop_front();
                chk("rgb", e.px, e.ln, 32'(rgb), 32'(e.rgb));
                chk("hsync_out", e.px, e.ln, 32'(hsync_out), 32'(e.hs));
                chk("vsync_out", e.px, e.ln, 32'(vsync_out), 32'(e.vs));
            end
            if (s1q.size() > 0 && s1q[0].due <= cyc) begin
                s1_exp_t s;
                s = s1q.pop_front();
                chk("fb_re", s.px, s.ln, 32'(fb_re), 32'(s.re));
                if (s.re) chk("fb_addr", s.px, s.ln, 32'(fb_addr), 32'(s.addr));
                chk("frame_cnt", s.px, s.ln, 32'(frame_cnt), 32'(s.frame));
                chk("mode_cur", s.px, s.ln, 32'(mode_cur), 32'(s.mode));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog px=0 ln=0 got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #12;
        chk("rst_rgb", 0, 0, 32'(rgb), 32'h000);
        chk("rst_hsync", 0, 0, 32'(hsync_out), 32'd1);
        chk("rst_vsync", 0, 0, 32'(vsync_out), 32'd0);
        chk("rst_fb_re", 0, 0, 32'(fb_re), 32'd0);
        chk("rst_fb_addr", 0, 0, 32'(fb_addr), 32'd0);
        chk("rst_frame", 0, 0, 32'(frame_cnt), 32'd0);
        chk("rst_mode", 0, 0, 32'(mode_cur), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Idle tail of the previous frame, then colour bars
        drive_span(448, 790, 799);
        mode_req = 2'd1;
        drive_span(0, 0, 799);
        drive_span(1, 630, 645);
        drive_span(411, 0, 5);
        drive_span(412, 0, 5);
        drive_span(414, 0, 5);

        // Framebuffer with a palette write colliding with a lookup of entry 5
        mode_req = 2'd0;
        for (int p = 0; p < 800; p++) begin
            if (p == 11) begin
                pw_addr  = 4'd5;
                pw_data  = 12'hA5C;
                pw_sched = 1'b1;
            end
            drive(p, 0);
        end
        drive_span(2, 0, 20);
        drive_span(399, 630, 645);

        // Mode request mid-frame is held off until the next boundary
        mode_req = 2'd2;
        drive_span(100, 0, 99);
        drive_span(0, 0, 63);
        drive_span(16, 0, 40);

        // Grid, including the last active pixel and line
        mode_req = 2'd3;
        drive_span(0, 0, 10);
        drive_span(5, 0, 70);
        drive_span(5, 630, 645);
        drive_span(399, 630, 645);

        // Checkerboard phase inverts at frame 32
        mode_req = 2'd2;
        while (m_frame != 31) drive(0, 0);
        drive_span(0, 0, 40);
        drive_span(16, 0, 20);

        // Frame counter wraps 255 -> 0
        mode_req = 2'd0;
        while (m_frame != 255) drive(0, 0);
        drive(0, 0);
        drive_span(0, 1, 4);

        // Reset in the middle of a framebuffer line
        drive_span(200, 290, 300);
        #2 reset = 1'b1;
        pq.delete();
        s1q.delete();
        model_reset();
        #1;
        chk("midrst_rgb", 300, 200, 32'(rgb), 32'h000);
        chk("midrst_hsync", 300, 200, 32'(hsync_out), 32'd1);
        chk("midrst_vsync", 300, 200, 32'(vsync_out), 32'd0);
        chk("midrst_fb_re", 300, 200, 32'(fb_re), 32'd0);
        chk("midrst_frame", 300, 200, 32'(frame_cnt), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        mode_req = 2'd2;
        drive_span(200, 301, 799);
        drive_span(0, 0, 40);
        drive_span(16, 0, 20);

        repeat (6) @(posedge clock);
        #1;
        chk("pix_queue_drained", 0, 0, 32'(pq.size()), 32'd0);
        chk("s1_queue_drained", 0, 0, 32'(s1q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
